merge_join: RTL and testbench
=============================

Name: merge_join

Overview:
- Clocked rejoin point that closes an if/else region: collects the completion request from whichever arm ran (true arm or false arm) and forwards a single four-phase request downstream.
- Each arm is acknowledged only after the downstream stage acknowledges, and the merge reports which arm completed.
- Counts completions per arm and flags illegal simultaneous arm requests.

Parameters:
- CNT_W, 8, width of the per-arm completion counters (wrap-around).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- reqTrue  input  1  four-phase level request from the true arm.
- reqFalse  input  1  four-phase level request from the false arm.
- ackTrue  output  1  acknowledge to the true arm.
- ackFalse  output  1  acknowledge to the false arm.
- reqOut  output  1  merged four-phase request to downstream.
- boolOut  output  1  arm that produced the current reqOut: 1 = true, 0 = false; stable while reqOut=1.
- ackOut  input  1  downstream acknowledge.
- errClr  input  1  synchronous clear of err.
- err  output  1  sticky flag: both arm requests were seen high in the same IDLE sample.
- cntTrue  output  CNT_W  number of true-arm completions.
- cntFalse  output  CNT_W  number of false-arm completions.

Behaviour:
- All outputs are registered.
- Reset values: ackTrue=0, ackFalse=0, reqOut=0, boolOut=0, err=0, cntTrue=0, cntFalse=0, state=IDLE, lastSel=0.
- While rst is high, all of the above are held at reset values.
- Reset mid-handshake: abandon the transfer and return to IDLE; inputs still high afterwards are treated as new requests.
- FSM states: IDLE, REQ, ACK, DROP.
- IDLE:
  - Samples reqTrue and reqFalse each cycle.
  - Exactly one high: latch sel (1 = true), drive reqOut=1 and boolOut=sel on the next edge, go to REQ. Latency is 1 cycle from arm request sampled to reqOut high.
  - Both high: set err=1. Serve the arm opposite lastSel (round-robin); sel is latched and the transfer proceeds as in the single-request case. The other arm's request stays pending and is served on a later IDLE visit.
  - Neither high: remain in IDLE.
- REQ: hold reqOut=1. When ackOut=1, assert the selected arm's ack, increment that arm's counter, set lastSel=sel, go to ACK.
- ACK: hold reqOut=1 and the arm ack. When the selected arm's req=0, drop reqOut, go to DROP.
- DROP: hold the arm ack. When ackOut=0, drop the arm ack, go to IDLE.
- Minimum full handshake: 4 cycles when the environment responds within one cycle.
- A new request is sampled no earlier than the IDLE cycle after the arm ack has fallen.
- The non-selected arm's request is ignored in REQ, ACK and DROP (no ack, no error). It is served from IDLE afterwards.
- The unselected arm's ack is always 0. ackTrue and ackFalse are never both 1.
- err:
  - Set on any IDLE cycle with both requests high.
  - errClr clears it on the next edge.
  - A set and a clear in the same cycle leave err=1 (set wins).
- Counters wrap from 2^CNT_W-1 to 0 with no saturation and no flag.
- boolOut changes only when leaving IDLE and holds its value until the next transfer.

Decomposition:
- Shared flow-control package holds:
  - State enum merge_state_t {IDLE, REQ, ACK, DROP}, 2-bit encoding.
  - Constants ARM_TRUE=1 and ARM_FALSE=0, shared with the branch block.
- Natural sub-module: merge_arb, a two-input round-robin arbiter with a lastSel register. It returns sel and a collision flag, and the FSM consumes both.
- Counters and FSM live in merge_join.

Test Plan:
- True-arm completion: raise reqTrue, downstream acks 1 cycle after reqOut -> reqOut=1 and boolOut=1 one cycle after reqTrue sampled; ackTrue rises after ackOut; ackFalse stays 0; cntTrue=1 after the handshake.
- Three false-arm completions back to back -> boolOut=0 for each, cntFalse=3, cntTrue=0, err=0.
- reqTrue and reqFalse high in the same cycle with lastSel=0 -> err=1; true arm served first, then false arm; final counts 1 and 1; errClr pulse -> err=0 next cycle.
- CNT_W=2, five true completions -> cntTrue sequence 1, 2, 3, 0, 1.
- rst asserted while in ACK -> all outputs 0 immediately; if reqTrue is still high after rst release, it is served again with cntTrue=1 and err=0.
- reqFalse raised while a true transfer is in REQ -> no ackFalse until the true handshake returns to IDLE; then the false transfer completes with boolOut=0.

Source files
------------

// File: rtl/merge_join_pkg.sv
// merge_join shared flow-control types.
// State encoding and arm identifiers.
package merge_join_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    DROP = 2'd3
  } merge_state_t;

  localparam logic ARM_TRUE  = 1'b1;
  localparam logic ARM_FALSE = 1'b0;

endpackage

// File: rtl/merge_arb.sv
// Two-input round-robin arbiter for the if/else rejoin.
// On collision it grants the arm opposite the last served one.
module merge_arb
  import merge_join_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_true_i,
  input  logic req_false_i,
  input  logic upd_i,
  input  logic upd_sel_i,
  output logic sel_o,
  output logic coll_o,
  output logic any_o
);

  logic last_sel_q;
  logic last_sel_d;

  // Remember the arm of the last completed transfer.
  always_comb begin
    last_sel_d = last_sel_q;
    if (upd_i) last_sel_d = upd_sel_i;
  end

  // Last-served register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_sel_q <= ARM_FALSE;
    else     last_sel_q <= last_sel_d;
  end

  // Grant: single requester wins, collision flips priority.
  always_comb begin
    coll_o = req_true_i & req_false_i;
    any_o  = req_true_i | req_false_i;
    sel_o  = req_true_i ? ARM_TRUE : ARM_FALSE;
    if (coll_o) sel_o = ~last_sel_q;
  end

endmodule

// File: rtl/merge_join.sv
// Rejoin point closing an if/else region: merges arm
// requests into one four-phase handshake downstream.
module merge_join
  import merge_join_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqTrue,
  input  logic             reqFalse,
  output logic             ackTrue,
  output logic             ackFalse,
  output logic             reqOut,
  output logic             boolOut,
  input  logic             ackOut,
  input  logic             errClr,
  output logic             err,
  output logic [CNT_W-1:0] cntTrue,
  output logic [CNT_W-1:0] cntFalse
);

  merge_state_t     state_q, state_d;
  logic             req_q, req_d;
  logic             bool_q, bool_d;
  logic             ack_t_q, ack_t_d;
  logic             ack_f_q, ack_f_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_t_q, cnt_t_d;
  logic [CNT_W-1:0] cnt_f_q, cnt_f_d;

  logic sel;
  logic coll;
  logic any;
  logic upd;
  logic arm_req;

  merge_arb u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_true_i  (reqTrue),
    .req_false_i (reqFalse),
    .upd_i       (upd),
    .upd_sel_i   (bool_q),
    .sel_o       (sel),
    .coll_o      (coll),
    .any_o       (any)
  );

  // Handshake sequencing, counters and sticky error.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    bool_d  = bool_q;
    ack_t_d = ack_t_q;
    ack_f_d = ack_f_q;
    cnt_t_d = cnt_t_q;
    cnt_f_d = cnt_f_q;
    upd     = 1'b0;
    err_d   = err_q & ~errClr;
    arm_req = (bool_q == ARM_TRUE) ? reqTrue : reqFalse;
    unique case (state_q)
      IDLE: begin
        if (coll) err_d = 1'b1;
        if (any) begin
          req_d   = 1'b1;
          bool_d  = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ackOut) begin
          upd     = 1'b1;
          state_d = ACK;
          if (bool_q == ARM_TRUE) begin
            ack_t_d = 1'b1;
            cnt_t_d = cnt_t_q + CNT_W'(1);
          end else begin
            ack_f_d = 1'b1;
            cnt_f_d = cnt_f_q + CNT_W'(1);
          end
        end
      end
      ACK: begin
        if (!arm_req) begin
          req_d   = 1'b0;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!ackOut) begin
          ack_t_d = 1'b0;
          ack_f_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      bool_q  <= 1'b0;
      ack_t_q <= 1'b0;
      ack_f_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_t_q <= '0;
      cnt_f_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      bool_q  <= bool_d;
      ack_t_q <= ack_t_d;
      ack_f_q <= ack_f_d;
      err_q   <= err_d;
      cnt_t_q <= cnt_t_d;
      cnt_f_q <= cnt_f_d;
    end
  end

  assign ackTrue  = ack_t_q;
  assign ackFalse = ack_f_q;
  assign reqOut   = req_q;
  assign boolOut  = bool_q;
  assign err      = err_q;
  assign cntTrue  = cnt_t_q;
  assign cntFalse = cnt_f_q;

endmodule

// File: tb/tb_merge_join.sv
// Bench for merge_join: handshake-level model plus
// directed arm/downstream scenarios on two counter widths.
module tb_merge_join;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic reqTrue = 1'b0;
  logic reqFalse = 1'b0;
  logic ackOut = 1'b0;
  logic errClr = 1'b0;

  logic ackTrue, ackFalse, reqOut, boolOut, err;
  logic [7:0] cntTrue, cntFalse;

  logic ackTrue2, ackFalse2, reqOut2, boolOut2, err2;
  logic [1:0] cntTrue2, cntFalse2;

  int n_chk = 0;
  int n_fail = 0;

  merge_join #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst),
    .reqTrue(reqTrue), .reqFalse(reqFalse),
    .ackTrue(ackTrue), .ackFalse(ackFalse),
    .reqOut(reqOut), .boolOut(boolOut),
    .ackOut(ackOut), .errClr(errClr),
    .err(err),
    .cntTrue(cntTrue), .cntFalse(cntFalse)
  );

  merge_join #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .reqTrue(reqTrue), .reqFalse(reqFalse),
    .ackTrue(ackTrue2), .ackFalse(ackFalse2),
    .reqOut(reqOut2), .boolOut(boolOut2),
    .ackOut(ackOut), .errClr(errClr),
    .err(err2),
    .cntTrue(cntTrue2), .cntFalse(cntFalse2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Downstream stage: acknowledges one cycle after reqOut.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ackOut = reqOut;
    end
  end

  // Handshake-level model state.
  logic m_req = 0, m_bool = 0, m_ack_t = 0, m_ack_f = 0;
  logic m_err = 0, m_last = 0;
  int   m_ct = 0, m_cf = 0;
  logic p_rst = 1, p_rt = 0, p_rf = 0, p_ao = 0, p_clr = 0;
  logic idle, n_err, want;

  task automatic model_reset();
    m_req = 0; m_bool = 0; m_ack_t = 0; m_ack_f = 0;
    m_err = 0; m_last = 0; m_ct = 0; m_cf = 0;
  endtask

  // Model step and compare, once per cycle away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || p_rst) begin
        model_reset();
      end else begin
        idle  = !m_req && !m_ack_t && !m_ack_f;
        n_err = (m_err && !p_clr) || (idle && p_rt && p_rf);
        if (idle) begin
          if (p_rt || p_rf) begin
            m_req  = 1;
            m_bool = (p_rt && p_rf) ? !m_last : p_rt;
          end
        end else if (m_req && !m_ack_t && !m_ack_f) begin
          if (p_ao) begin
            if (m_bool) begin m_ack_t = 1; m_ct++; end
            else        begin m_ack_f = 1; m_cf++; end
            m_last = m_bool;
          end
        end else if (m_req) begin
          want = m_bool ? p_rt : p_rf;
          if (!want) m_req = 0;
        end else begin
          if (!p_ao) begin m_ack_t = 0; m_ack_f = 0; end
        end
        m_err = n_err;
      end
      chk("reqOut", reqOut, m_req);
      chk("boolOut", boolOut, m_bool);
      chk("ackTrue", ackTrue, m_ack_t);
      chk("ackFalse", ackFalse, m_ack_f);
      chk("err", err, m_err);
      chk("cntTrue", cntTrue, m_ct % 256);
      chk("cntFalse", cntFalse, m_cf % 256);
      chk("reqOut2", reqOut2, m_req);
      chk("ackTrue2", ackTrue2, m_ack_t);
      chk("ackFalse2", ackFalse2, m_ack_f);
      chk("cntTrue2", cntTrue2, m_ct % 4);
      chk("cntFalse2", cntFalse2, m_cf % 4);
      p_rst = rst; p_rt = reqTrue; p_rf = reqFalse;
      p_ao = ackOut; p_clr = errClr;
    end
  end

  // One four-phase transfer from an arm, bounded waits.
  task automatic arm(input logic t);
    int n;
    if (t) reqTrue = 1; else reqFalse = 1;
    n = 0;
    while (!(t ? ackTrue : ackFalse) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("arm_ack_rise", t ? ackTrue : ackFalse, 1);
    chk("arm_bool", boolOut, t);
    chk("arm_other_ack", t ? ackFalse : ackTrue, 0);
    if (t) reqTrue = 0; else reqFalse = 0;
    n = 0;
    while ((t ? ackTrue : ackFalse) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("arm_ack_fall", t ? ackTrue : ackFalse, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: test did not finish");
    n_fail++;
    $fatal(1, "watchdog");
  end

  int exp_w[5] = '{1, 2, 3, 0, 1};
  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_reqOut", reqOut, 0);
    chk("rst_cnt", cntTrue, 0);
    chk("rst_err", err, 0);

    // True-arm completion with latency check.
    reqTrue = 1;
    @(posedge clk); #1;
    chk("lat_reqOut", reqOut, 1);
    chk("lat_bool", boolOut, 1);
    arm(1);
    chk("t1_cntTrue", cntTrue, 1);
    chk("t1_ackFalse", ackFalse, 0);

    // Three false completions back to back.
    do_reset();
    for (int i = 0; i < 3; i++) arm(0);
    chk("t2_cntFalse", cntFalse, 3);
    chk("t2_cntTrue", cntTrue, 0);
    chk("t2_err", err, 0);

    // Collision after reset: true first, then false.
    do_reset();
    fork
      arm(1);
      arm(0);
    join
    chk("t3_err", err, 1);
    chk("t3_cntTrue", cntTrue, 1);
    chk("t3_cntFalse", cntFalse, 1);
    errClr = 1;
    @(posedge clk); #1;
    errClr = 0;
    chk("t3_errclr", err, 0);

    // Counter wrap on the 2-bit instance.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      arm(1);
      chk("wrap_cnt2", cntTrue2, exp_w[i]);
      chk("wrap_cnt8", cntTrue, i + 1);
    end

    // Reset while in ACK, request still held.
    do_reset();
    reqTrue = 1;
    n = 0;
    while (!ackTrue && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_in_ack", ackTrue, 1);
    rst = 1;
    #1;
    chk("t5_rst_ack", ackTrue, 0);
    chk("t5_rst_req", reqOut, 0);
    chk("t5_rst_cnt", cntTrue, 0);
    @(posedge clk); #1;
    rst = 0;
    arm(1);
    chk("t5_cntTrue", cntTrue, 1);
    chk("t5_err", err, 0);

    // False request raised during a true transfer.
    do_reset();
    fork
      arm(1);
      begin
        @(posedge clk); #1;
        arm(0);
      end
    join
    chk("t6_cntTrue", cntTrue, 1);
    chk("t6_cntFalse", cntFalse, 1);
    chk("t6_err", err, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
